// File: rtl/present_sprite_renderer.sv
// Present-box sprite renderer: turns scan coordinates into sprite RAM
// addresses, runs the frame-animation sequencer, and maps the returned
// palette index to RGB. Palette index 0 is transparent.
//
// Output timing: a pixel presented on DrawX/DrawY at edge N appears on
// sprite_on/RGB after edge N+2. The RAM returns ram_data one cycle after
// read_address, so the in-sprite flag is delayed one stage to line up
// with ram_data.
//
// There is no valid/ready handshake. frame_start and start are
// single-cycle strobes, each sampled on the rising clock edge.
// start takes priority over frame_start when both arrive in one cycle.
module present_sprite_renderer #(
  parameter int SPR_W           = 108,
  parameter int SPR_H           = 108,
  parameter int NUM_FRAMES      = 6,
  parameter int FRAMES_PER_STEP = 8,
  parameter bit LOOP            = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        frame_start,
  input  logic        start,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  output logic [13:0] read_address,
  output logic [2:0]  cs,
  input  logic [2:0]  ram_data,
  output logic        sprite_on,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        anim_done,
  output logic [1:0]  anim_state
);

  localparam int DIV_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [2:0]       cs_next;
  logic [DIV_W-1:0] div, div_next;
  logic             in_spr, in_spr_d;
  logic [13:0]      dx, dy;
  logic [23:0]      rgb_next;

  // The right and bottom edges are widened to 11 bits so that they do not
  // wrap when the sprite sits near the right or bottom of the screen.
  assign in_spr = ({1'b0, DrawX} >= {1'b0, sprite_x}) &&
                  ({1'b0, DrawX} <  ({1'b0, sprite_x} + 11'(SPR_W))) &&
                  ({1'b0, DrawY} >= {1'b0, sprite_y}) &&
                  ({1'b0, DrawY} <  ({1'b0, sprite_y} + 11'(SPR_H)));

  assign dx           = 14'(DrawX - sprite_x);
  assign dy           = 14'(DrawY - sprite_y);
  assign read_address = in_spr ? 14'(dy * 14'(SPR_W) + dx) : 14'd0;
  assign anim_state   = state;

  // Palette lookup for the returned index. Index 0 is transparent.
  always_comb begin
    rgb_next = 24'h000000;
    case (ram_data)
      3'd1:    rgb_next = 24'hFF0000;
      3'd2:    rgb_next = 24'h00A000;
      3'd3:    rgb_next = 24'hFFD700;
      3'd4:    rgb_next = 24'hFFFFFF;
      3'd5:    rgb_next = 24'h000000;
      3'd6:    rgb_next = 24'h8B4513;
      3'd7:    rgb_next = 24'hC0C0C0;
      default: rgb_next = 24'h000000;
    endcase
  end

  // Pixel pipeline. The in-sprite flag is delayed one stage so it lines up
  // with ram_data. A pixel is shown only when it is inside the sprite and
  // its palette index is not transparent.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_spr_d  <= 1'b0;
      sprite_on <= 1'b0;
      Red       <= 8'd0;
      Green     <= 8'd0;
      Blue      <= 8'd0;
    end else begin
      in_spr_d  <= in_spr;
      sprite_on <= in_spr_d && (ram_data != 3'd0);
      if (in_spr_d && (ram_data != 3'd0)) begin
        {Red, Green, Blue} <= rgb_next;
      end else begin
        {Red, Green, Blue} <= 24'h000000;
      end
    end
  end

  // Animation state register. cs changes only on a start or frame_start
  // edge, so the frame never changes partway through a line.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      cs        <= 3'd0;
      div       <= '0;
      anim_done <= 1'b0;
    end else begin
      state     <= state_next;
      cs        <= cs_next;
      div       <= div_next;
      anim_done <= (state_next == DONE);
    end
  end

  // Animation next-state logic. start overrides frame_start in every state.
  always_comb begin
    state_next = state;
    cs_next    = cs;
    div_next   = div;
    if (start) begin
      state_next = PLAY;
      cs_next    = 3'd0;
      div_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          cs_next = 3'd0;
        end
        PLAY: begin
          if (frame_start) begin
            if (div == DIV_W'(FRAMES_PER_STEP - 1)) begin
              div_next = '0;
              if (cs < 3'(NUM_FRAMES - 1)) begin
                cs_next = cs + 3'd1;
              end else if (LOOP) begin
                cs_next = 3'd0;
              end else begin
                state_next = DONE;
              end
            end else begin
              div_next = div + DIV_W'(1);
            end
          end
        end
        DONE: begin
          cs_next = cs;
        end
        default: begin
          state_next = IDLE;
          cs_next    = 3'd0;
          div_next   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_present_sprite_renderer.sv
// Directed bench for present_sprite_renderer. Two instances share all
// inputs: u_loop wraps the animation, u_stop stops on the last frame.
module tb_present_sprite_renderer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        frame_start = 1'b0, start = 1'b0;
  logic [9:0]  sprite_x = '0, sprite_y = '0;
  logic [2:0]  ram_data = '0;

  logic [13:0] ra_l, ra_s;
  logic [2:0]  cs_l, cs_s;
  logic        on_l, on_s, done_l, done_s;
  logic [7:0]  r_l, g_l, b_l, r_s, g_s, b_s;
  logic [1:0]  st_l, st_s;

  int vectors = 0;
  int miscompares = 0;

  present_sprite_renderer #(.LOOP(1'b1)) u_loop (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .frame_start(frame_start), .start(start),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
    .read_address(ra_l), .cs(cs_l), .ram_data(ram_data),
    .sprite_on(on_l), .Red(r_l), .Green(g_l), .Blue(b_l),
    .anim_done(done_l), .anim_state(st_l)
  );

  present_sprite_renderer #(.LOOP(1'b0)) u_stop (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .frame_start(frame_start), .start(start),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
    .read_address(ra_s), .cs(cs_s), .ram_data(ram_data),
    .sprite_on(on_s), .Red(r_s), .Green(g_s), .Blue(b_s),
    .anim_done(done_s), .anim_state(st_s)
  );

  // Clock
  always #5 Clk = ~Clk;

  // Advance one clock edge, then settle 1 time unit past it
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Pulse frame_start n times, with one idle cycle after each pulse
  task automatic fs_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    Reset = 1'b1;
    tick();
    tick();
    chk("rst_cs", {29'd0, cs_l}, 32'd0);
    chk("rst_on", {31'd0, on_l}, 32'd0);
    chk("rst_rgb", {8'd0, r_l, g_l, b_l}, 32'h0);
    chk("rst_done", {31'd0, done_s}, 32'd0);
    chk("rst_state", {30'd0, st_l}, 32'd0);
    Reset = 1'b0;

    // Top-left pixel of the sprite, with palette index 3
    sprite_x = 10'd100;
    sprite_y = 10'd50;
    DrawX = 10'd100;
    DrawY = 10'd50;
    #1;
    chk("addr_origin", {18'd0, ra_l}, 32'd0);
    tick();
    ram_data = 3'd3;
    tick();
    chk("on_origin", {31'd0, on_l}, 32'd1);
    chk("rgb_idx3", {8'd0, r_l, g_l, b_l}, 32'hFFD700);

    // Bottom-right pixel, then one column past the right edge
    DrawX = 10'd207;
    DrawY = 10'd157;
    #1;
    chk("addr_last", {18'd0, ra_l}, 32'd11663);
    DrawX = 10'd208;
    ram_data = 3'd5;
    #1;
    chk("addr_right_out", {18'd0, ra_l}, 32'd0);
    tick();
    tick();
    chk("on_right_out", {31'd0, on_s}, 32'd0);
    chk("rgb_right_out", {8'd0, r_s, g_s, b_s}, 32'h0);

    // Left and bottom edges just outside the sprite
    DrawX = 10'd99;
    DrawY = 10'd60;
    #1;
    chk("addr_left_out", {18'd0, ra_l}, 32'd0);
    DrawX = 10'd100;
    DrawY = 10'd158;
    #1;
    chk("addr_bottom_out", {18'd0, ra_l}, 32'd0);

    // Interior pixel: offset (10,2) -> 2*108 + 10 = 226
    DrawX = 10'd110;
    DrawY = 10'd52;
    #1;
    chk("addr_interior", {18'd0, ra_l}, 32'd226);

    // Palette index 0 is transparent
    ram_data = 3'd0;
    tick();
    tick();
    chk("on_transparent", {31'd0, on_l}, 32'd0);
    chk("rgb_transparent", {8'd0, r_l, g_l, b_l}, 32'h0);

    // Further palette entries
    ram_data = 3'd6;
    tick();
    tick();
    chk("on_idx6", {31'd0, on_l}, 32'd1);
    chk("rgb_idx6", {8'd0, r_l, g_l, b_l}, 32'h8B4513);
    ram_data = 3'd2;
    tick();
    chk("rgb_idx2", {8'd0, r_l, g_l, b_l}, 32'h00A000);
    ram_data = 3'd7;
    tick();
    chk("rgb_idx7", {8'd0, r_l, g_l, b_l}, 32'hC0C0C0);

    // Animation sequencer: frames advance every 8 frame_start pulses
    fs_pulses(8);
    chk("idle_ignores_fs", {29'd0, cs_l}, 32'd0);
    pulse_start();
    chk("play_state", {30'd0, st_l}, 32'd1);
    chk("play_cs0", {29'd0, cs_l}, 32'd0);
    fs_pulses(7);
    chk("cs_after7", {29'd0, cs_l}, 32'd0);
    fs_pulses(1);
    chk("cs_after8", {29'd0, cs_l}, 32'd1);
    fs_pulses(40);
    chk("loop_wrap_cs", {29'd0, cs_l}, 32'd0);
    chk("loop_not_done", {31'd0, done_l}, 32'd0);
    chk("stop_cs5", {29'd0, cs_s}, 32'd5);
    chk("stop_done", {31'd0, done_s}, 32'd1);
    chk("stop_state", {30'd0, st_s}, 32'd2);
    fs_pulses(8);
    chk("stop_hold_cs", {29'd0, cs_s}, 32'd5);
    chk("stop_hold_done", {31'd0, done_s}, 32'd1);
    chk("loop_cs_after56", {29'd0, cs_l}, 32'd1);
    pulse_start();
    chk("restart_cs", {29'd0, cs_s}, 32'd0);
    chk("restart_done", {31'd0, done_s}, 32'd0);

    // start and frame_start in the same cycle with div at 7
    fs_pulses(15);
    chk("pre_collide_cs", {29'd0, cs_l}, 32'd1);
    start = 1'b1;
    frame_start = 1'b1;
    tick();
    start = 1'b0;
    frame_start = 1'b0;
    chk("collide_cs", {29'd0, cs_l}, 32'd0);
    fs_pulses(7);
    chk("collide_div_cleared", {29'd0, cs_l}, 32'd0);
    fs_pulses(1);
    chk("collide_next_step", {29'd0, cs_l}, 32'd1);

    // Reset in the middle of the animation while a pixel is being drawn
    ram_data = 3'd1;
    tick();
    tick();
    chk("pre_reset_on", {31'd0, on_l}, 32'd1);
    chk("pre_reset_rgb", {8'd0, r_l, g_l, b_l}, 32'hFF0000);
    Reset = 1'b1;
    tick();
    chk("midrst_state", {30'd0, st_l}, 32'd0);
    chk("midrst_cs", {29'd0, cs_l}, 32'd0);
    chk("midrst_on", {31'd0, on_l}, 32'd0);
    chk("midrst_rgb", {8'd0, r_l, g_l, b_l}, 32'h0);
    Reset = 1'b0;
    fs_pulses(8);
    chk("post_rst_idle_cs", {29'd0, cs_l}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
